// File: rtl/noc_pkg.sv
// Shared router definitions: default sizes, port indices and the flit type.
package noc_pkg;

   localparam int unsigned NPORTS_DEF     = 5;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned DEPTH_DEF      = 4;

   typedef enum logic [2:0] {
      NORTH = 3'd0,
      SOUTH = 3'd1,
      EAST  = 3'd2,
      WEST  = 3'd3,
      LOCAL = 3'd4
   } port_e;

   typedef logic [DATA_WIDTH_DEF-1:0] flit_t;

   // Occupancy counter width: must hold the value DEPTH itself.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_buffer.sv
// Single first-word-fall-through FIFO for one router input port.
module fifo_buffer
   import noc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [DATA_WIDTH-1:0]     din,
   input  logic                      rd_en,
   output logic [DATA_WIDTH-1:0]     dout,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  wr_accept;
   logic                  rd_accept;

   // Accept decisions and next-state for pointers and occupancy.
   always_comb begin
      wr_accept = wr_en && !full;
      rd_accept = rd_en && !empty;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (!rst && wr_accept) mem_q[wr_ptr_q] <= din;
   end

   // Status flags and head flit, all from registered state.
   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == CntW'(DEPTH));
      count = count_q;
      dout  = empty ? '0 : mem_q[rd_ptr_q];
   end

endmodule

// File: rtl/input_buffers.sv
// Input-buffer stage of a mesh router: one independent FIFO per input port.
module input_buffers
   import noc_pkg::*;
#(
   parameter int unsigned NPORTS     = NPORTS_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NPORTS-1:0]                    wr_en,
   input  logic [NPORTS*DATA_WIDTH-1:0]         data_in,
   input  logic [NPORTS-1:0]                    rd_en,
   output logic [NPORTS*DATA_WIDTH-1:0]         data_out,
   output logic [NPORTS-1:0]                    empty,
   output logic [NPORTS-1:0]                    full,
   output logic [NPORTS*($clog2(DEPTH)+1)-1:0]  count
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   // One FIFO per port; the top only slices the packed buses.
   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      fifo_buffer #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .wr_en (wr_en[p]),
         .din   (data_in[p*DATA_WIDTH +: DATA_WIDTH]),
         .rd_en (rd_en[p]),
         .dout  (data_out[p*DATA_WIDTH +: DATA_WIDTH]),
         .empty (empty[p]),
         .full  (full[p]),
         .count (count[p*CntW +: CntW])
      );
   end

endmodule

// File: tb/tb_input_buffers.sv
// Bench for input_buffers: per-port queue model plus directed and random traffic.
module tb_input_buffers;
   import noc_pkg::*;

   localparam int unsigned NP = NPORTS_DEF;
   localparam int unsigned DW = DATA_WIDTH_DEF;
   localparam int unsigned DP = DEPTH_DEF;
   localparam int unsigned CW = $clog2(DP) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     wr_en;
   logic [NP*DW-1:0]  data_in;
   logic [NP-1:0]     rd_en;
   logic [NP*DW-1:0]  data_out;
   logic [NP-1:0]     empty;
   logic [NP-1:0]     full;
   logic [NP*CW-1:0]  count;

   int n_vec  = 0;
   int n_err  = 0;
   bit active = 1'b0;

   flit_t mq [NP][$];

   input_buffers dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .data_in  (data_in),
      .rd_en    (rd_en),
      .data_out (data_out),
      .empty    (empty),
      .full     (full),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain queue per port, updated from the inputs seen at each edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NP; p++) mq[p].delete();
         active <= 1'b1;
      end else begin
         for (int p = 0; p < NP; p++) begin
            bit do_w, do_r;
            do_w = wr_en[p] && (mq[p].size() < DP);
            do_r = rd_en[p] && (mq[p].size() > 0);
            if (do_r) void'(mq[p].pop_front());
            if (do_w) mq[p].push_back(data_in[p*DW +: DW]);
         end
      end
   end

   // Compare every port against the model on the falling edge.
   always @(negedge clk) begin
      if (active) begin
         for (int p = 0; p < NP; p++) begin
            int    n;
            flit_t head;
            n    = mq[p].size();
            head = (n > 0) ? mq[p][0] : '0;
            check($sformatf("p%0d data_out", p), data_out[p*DW +: DW], head);
            check($sformatf("p%0d count", p), 32'(count[p*CW +: CW]), 32'(n));
            check($sformatf("p%0d empty", p), 32'(empty[p]), 32'(n == 0));
            check($sformatf("p%0d full", p), 32'(full[p]), 32'(n == DP));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      wr_en = '0;
      rd_en = '0;
   endtask

   task automatic put(input int p, input flit_t d);
      wr_en[p] = 1'b1;
      data_in[p*DW +: DW] = d;
   endtask

   function automatic logic [31:0] cnt_of(input int p);
      return 32'(count[p*CW +: CW]);
   endfunction

   function automatic logic [31:0] head_of(input int p);
      return data_out[p*DW +: DW];
   endfunction

   initial begin
      rst = 1'b0;
      idle();
      data_in = '0;
      #2;

      // Reset with random traffic on the enables.
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wr_en   = NP'($urandom);
         rd_en   = NP'($urandom);
         data_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      rst = 1'b0;
      idle();
      check("reset empty", 32'(empty), 32'h1f);
      check("reset full", 32'(full), 32'h0);
      check("reset count", 32'(count), 32'h0);
      check("reset data_out p0", head_of(0), 32'h0);
      check("reset data_out p4", head_of(4), 32'h0);

      // Port 0 fill and drain.
      for (int i = 1; i <= 4; i++) begin
         put(int'(NORTH), flit_t'(i));
         cyc();
         idle();
      end
      check("p0 full after fill", 32'(full[0]), 32'h1);
      check("p0 count after fill", cnt_of(0), 32'd4);
      check("p0 head after fill", head_of(0), 32'h1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("p0 drain %0d", i), head_of(0), 32'(i));
         rd_en[0] = 1'b1;
         cyc();
         idle();
      end
      check("p0 empty after drain", 32'(empty[0]), 32'h1);

      // Port 2 overflow then underflow.
      for (int i = 0; i < 4; i++) begin
         put(int'(EAST), flit_t'(32'hA0 + i));
         cyc();
         idle();
      end
      put(int'(EAST), 32'hFF);
      cyc();
      idle();
      check("p2 count after overflow", cnt_of(2), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("p2 drain %0d", i), head_of(2), 32'hA0 + i);
         rd_en[2] = 1'b1;
         cyc();
         idle();
      end
      rd_en[2] = 1'b1;
      cyc();
      idle();
      check("p2 count after underflow", cnt_of(2), 32'd0);

      // Port 4 simultaneous read and write at partial, full and empty.
      put(int'(LOCAL), 32'h10); cyc(); idle();
      put(int'(LOCAL), 32'h11); cyc(); idle();
      put(int'(LOCAL), 32'h12); rd_en[4] = 1'b1; cyc(); idle();
      check("p4 count wr+rd mid", cnt_of(4), 32'd2);
      check("p4 head wr+rd mid", head_of(4), 32'h11);
      put(int'(LOCAL), 32'h13); cyc(); idle();
      put(int'(LOCAL), 32'h14); cyc(); idle();
      put(int'(LOCAL), 32'h15); rd_en[4] = 1'b1; cyc(); idle();
      check("p4 count wr+rd full", cnt_of(4), 32'd3);
      check("p4 head wr+rd full", head_of(4), 32'h12);
      for (int i = 0; i < 3; i++) begin
         rd_en[4] = 1'b1;
         cyc();
         idle();
      end
      check("p4 tail flit not the dropped one", cnt_of(4), 32'd0);
      put(int'(LOCAL), 32'h16); rd_en[4] = 1'b1; cyc(); idle();
      check("p4 count wr+rd empty", cnt_of(4), 32'd1);
      check("p4 head wr+rd empty", head_of(4), 32'h16);
      rd_en[4] = 1'b1; cyc(); idle();

      // Port 1 pointer wrap while port 3 fills concurrently.
      for (int i = 0; i < 10; i++) begin
         put(int'(SOUTH), flit_t'(32'h100 + i));
         put(int'(WEST), flit_t'(32'hDEAD_0000 + i));
         cyc();
         idle();
         check($sformatf("p1 wrap head %0d", i), head_of(1), 32'h100 + i);
         rd_en[1] = 1'b1;
         cyc();
         idle();
      end
      check("p3 count after fill", cnt_of(3), 32'd4);
      check("p3 head after fill", head_of(3), 32'hDEAD_0000);
      check("p1 empty after wrap", 32'(empty[1]), 32'h1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 49) == 0);
         wr_en   = NP'($urandom);
         rd_en   = NP'($urandom);
         data_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;

      // Mid-operation reset discards everything.
      for (int i = 0; i < 3; i++) begin
         wr_en   = '1;
         data_in = {5{32'hC0DE_0000 + 32'(i)}};
         cyc();
      end
      idle();
      check("all count 3", 32'(count), {17'h0, {5{3'd3}}});
      rst   = 1'b1;
      wr_en = '1;
      rd_en = '1;
      cyc();
      rst = 1'b0;
      idle();
      check("mid reset empty", 32'(empty), 32'h1f);
      check("mid reset count", 32'(count), 32'h0);
      put(0, 32'h5A5A_5A5A);
      cyc();
      idle();
      check("head after reset", head_of(0), 32'h5A5A_5A5A);
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
